// File: rtl/sram_pkg.sv
// sram_pkg: shared types and constants for the SRAM responder slice.
//   - sramState_t : controller states (IDLE / INIT / DUMP)
//   - PAT_*       : init-pattern select codes; INIT_FILL_BYTE is the pattern-3 byte
//   - SRAM_DATA_W : default word width; SRAM_REQ_ADDR_W : request address width
package sram_pkg;

    localparam int unsigned SRAM_DATA_W     = 128;
    localparam int unsigned SRAM_REQ_ADDR_W = 16;
    localparam int unsigned SRAM_SEL_W      = 3;

    localparam logic [SRAM_SEL_W-1:0] PAT_ZERO  = 3'd0;
    localparam logic [SRAM_SEL_W-1:0] PAT_ONES  = 3'd1;
    localparam logic [SRAM_SEL_W-1:0] PAT_INDEX = 3'd2;
    localparam logic [SRAM_SEL_W-1:0] PAT_A5    = 3'd3;

    localparam logic [7:0] INIT_FILL_BYTE = 8'hA5;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        INIT = 2'd1,
        DUMP = 2'd2
    } sramState_t;

endpackage

// File: rtl/sram_responder_if.sv
// sram_responder_if: request/response bundle between an array-processing
// initiator (master) and sram_responder (slave).
//   requests : sramRead, sramWrite, sramAddr, sramWriteValue,
//              sramInit/sramInitNum, sramDump/sramDumpNum
//   responses: sramReadValue, sramReadValid, sramReady, sramAddrErr,
//              initDone, dumpValid, dumpLast, dumpAddr, dumpData
interface sram_responder_if #(
    parameter int unsigned DATA_W = sram_pkg::SRAM_DATA_W
);
    import sram_pkg::*;

    logic                       sramRead;
    logic                       sramWrite;
    logic [SRAM_REQ_ADDR_W-1:0] sramAddr;
    logic [DATA_W-1:0]          sramWriteValue;
    logic [DATA_W-1:0]          sramReadValue;
    logic                       sramReadValid;
    logic                       sramReady;
    logic                       sramAddrErr;
    logic                       sramInit;
    logic [SRAM_SEL_W-1:0]      sramInitNum;
    logic                       sramDump;
    logic [SRAM_SEL_W-1:0]      sramDumpNum;
    logic                       initDone;
    logic                       dumpValid;
    logic                       dumpLast;
    logic [SRAM_REQ_ADDR_W-1:0] dumpAddr;
    logic [DATA_W-1:0]          dumpData;

    modport master (
        output sramRead, sramWrite, sramAddr, sramWriteValue,
               sramInit, sramInitNum, sramDump, sramDumpNum,
        input  sramReadValue, sramReadValid, sramReady, sramAddrErr,
               initDone, dumpValid, dumpLast, dumpAddr, dumpData
    );

    modport slave (
        input  sramRead, sramWrite, sramAddr, sramWriteValue,
               sramInit, sramInitNum, sramDump, sramDumpNum,
        output sramReadValue, sramReadValid, sramReady, sramAddrErr,
               initDone, dumpValid, dumpLast, dumpAddr, dumpData
    );

endinterface

// File: rtl/sram_store.sv
// sram_store: DEPTH x DATA_W storage array, one synchronous write port and
// one synchronous (registered) read port. No reset: contents survive rst.
//   clk          : rising-edge clock
//   we/wAddr/wData : write port
//   re/rAddr     : read port request; rData updates at the edge when re=1
module sram_store
    import sram_pkg::*;
#(
    parameter int unsigned ADDR_BITS = 6,
    parameter int unsigned DATA_W    = SRAM_DATA_W
) (
    input  logic                 clk,
    input  logic                 we,
    input  logic [ADDR_BITS-1:0] wAddr,
    input  logic [DATA_W-1:0]    wData,
    input  logic                 re,
    input  logic [ADDR_BITS-1:0] rAddr,
    output logic [DATA_W-1:0]    rData
);

    localparam int unsigned DEPTH = 1 << ADDR_BITS;

    logic [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) mem[wAddr] <= wData;
        if (re) rData <= mem[rAddr];
    end

endmodule

// File: rtl/sram_responder.sv
// sram_responder: responder end of the 128-bit SRAM request interface.
// Serves single-word reads/writes, fills the store with a pattern (init)
// and streams one eighth of the store out of the dump port (dump).
//   clk, rst : clock, asynchronous active-high reset
//   bus      : sram_responder_if slave modport (requests in, responses out)
module sram_responder
    import sram_pkg::*;
#(
    parameter int unsigned ADDR_BITS = 6,
    parameter int unsigned DATA_W    = SRAM_DATA_W
) (
    input  logic            clk,
    input  logic            rst,
    sram_responder_if.slave bus
);

    localparam int unsigned DEPTH        = 1 << ADDR_BITS;
    localparam int unsigned REGION_WORDS = DEPTH / 8;
    localparam int unsigned REGION_SHIFT = ADDR_BITS - 3;

    sramState_t             state, stateNext;
    logic [ADDR_BITS-1:0]   cnt, cntNext;
    logic [SRAM_SEL_W-1:0]  initSel, initSelNext;
    logic [SRAM_SEL_W-1:0]  region, regionNext;
    logic                   readValid, readValidNext;
    logic                   readErr, readErrNext;
    logic                   addrErr, addrErrNext;
    logic                   initDone, initDoneNext;
    logic                   dumpValid, dumpValidNext;
    logic                   dumpLast, dumpLastNext;
    logic [SRAM_REQ_ADDR_W-1:0] dumpAddr, dumpAddrNext;
    logic [DATA_W-1:0]      readHold, dumpHold;

    logic                   memWe, memRe;
    logic [ADDR_BITS-1:0]   memWAddr, memRAddr;
    logic [DATA_W-1:0]      memWData, memRData;
    logic [DATA_W-1:0]      initWord;
    logic [DATA_W-1:0]      readValue, dumpValue;
    logic [ADDR_BITS-1:0]   wordAddr, dumpBase;
    logic                   addrOob;

    assign wordAddr = bus.sramAddr[ADDR_BITS-1:0];
    assign addrOob  = |bus.sramAddr[SRAM_REQ_ADDR_W-1:ADDR_BITS];
    assign dumpBase = ADDR_BITS'(region) << REGION_SHIFT;

    // Pattern word written at init position cnt
    always_comb begin
        initWord = '0;
        case (initSel)
            PAT_ZERO:  initWord = '0;
            PAT_ONES:  initWord = '1;
            PAT_INDEX: initWord = DATA_W'(cnt);
            PAT_A5:    initWord = DATA_W'({(DATA_W / 8){INIT_FILL_BYTE}});
            default:   initWord = '0;
        endcase
    end

    // Next-state, counters, store port control and registered-output next values
    always_comb begin
        stateNext     = state;
        cntNext       = cnt;
        initSelNext   = initSel;
        regionNext    = region;
        readValidNext = 1'b0;
        readErrNext   = 1'b0;
        addrErrNext   = 1'b0;
        initDoneNext  = 1'b0;
        dumpValidNext = 1'b0;
        dumpLastNext  = 1'b0;
        dumpAddrNext  = dumpAddr;
        memWe         = 1'b0;
        memWAddr      = wordAddr;
        memWData      = bus.sramWriteValue;
        memRe         = 1'b0;
        memRAddr      = wordAddr;

        case (state)
            IDLE: begin
                if (bus.sramInit) begin
                    stateNext   = INIT;
                    cntNext     = '0;
                    initSelNext = bus.sramInitNum;
                end else if (bus.sramDump) begin
                    stateNext  = DUMP;
                    cntNext    = '0;
                    regionNext = bus.sramDumpNum;
                end else if (bus.sramWrite) begin
                    memWe       = ~addrOob;
                    addrErrNext = addrOob;
                end else if (bus.sramRead) begin
                    memRe         = 1'b1;
                    readValidNext = 1'b1;
                    readErrNext   = addrOob;
                    addrErrNext   = addrOob;
                end
            end
            INIT: begin
                memWe    = 1'b1;
                memWAddr = cnt;
                memWData = initWord;
                if (cnt == ADDR_BITS'(DEPTH - 1)) begin
                    stateNext    = IDLE;
                    initDoneNext = 1'b1;
                end else begin
                    cntNext = cnt + ADDR_BITS'(1);
                end
            end
            DUMP: begin
                // First DUMP cycle only sets up; the stream ends one cycle after dumpLast
                if (dumpValid && dumpLast) begin
                    stateNext = IDLE;
                end else begin
                    memRe         = 1'b1;
                    memRAddr      = dumpBase + cnt;
                    dumpValidNext = 1'b1;
                    dumpAddrNext  = SRAM_REQ_ADDR_W'(dumpBase + cnt);
                    dumpLastNext  = (cnt == ADDR_BITS'(REGION_WORDS - 1));
                    cntNext       = cnt + ADDR_BITS'(1);
                end
            end
            default: stateNext = IDLE;
        endcase
    end

    // Data outputs show the store read register on their strobe cycle, else hold
    assign readValue = readValid ? (readErr ? '0 : memRData) : readHold;
    assign dumpValue = dumpValid ? memRData : dumpHold;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= '0;
            initSel   <= '0;
            region    <= '0;
            readValid <= 1'b0;
            readErr   <= 1'b0;
            addrErr   <= 1'b0;
            initDone  <= 1'b0;
            dumpValid <= 1'b0;
            dumpLast  <= 1'b0;
            dumpAddr  <= '0;
            readHold  <= '0;
            dumpHold  <= '0;
        end else begin
            state     <= stateNext;
            cnt       <= cntNext;
            initSel   <= initSelNext;
            region    <= regionNext;
            readValid <= readValidNext;
            readErr   <= readErrNext;
            addrErr   <= addrErrNext;
            initDone  <= initDoneNext;
            dumpValid <= dumpValidNext;
            dumpLast  <= dumpLastNext;
            dumpAddr  <= dumpAddrNext;
            readHold  <= readValue;
            dumpHold  <= dumpValue;
        end
    end

    sram_store #(
        .ADDR_BITS (ADDR_BITS),
        .DATA_W    (DATA_W)
    ) u_store (
        .clk   (clk),
        .we    (memWe & ~rst),
        .wAddr (memWAddr),
        .wData (memWData),
        .re    (memRe),
        .rAddr (memRAddr),
        .rData (memRData)
    );

    assign bus.sramReady     = (state == IDLE) && !rst;
    assign bus.sramReadValue = readValue;
    assign bus.sramReadValid = readValid;
    assign bus.sramAddrErr   = addrErr;
    assign bus.initDone      = initDone;
    assign bus.dumpValid     = dumpValid;
    assign bus.dumpLast      = dumpLast;
    assign bus.dumpAddr      = dumpAddr;
    assign bus.dumpData      = dumpValue;

endmodule

// File: tb/tb_sram_responder.sv
// tb_sram_responder: directed stimulus for sram_responder with a queue-based
// scoreboard; a negedge monitor pops expected read/dump responses.
module tb_sram_responder;

    localparam logic [127:0] A5W   = {16{8'hA5}};
    localparam logic [127:0] ONESW = {128{1'b1}};
    localparam logic [127:0] BEEF  = 128'h0123_4567_89AB_CDEF_0000_0000_DEAD_BEEF;
    localparam logic [127:0] W6    = 128'h1111_2222_3333_4444_5555_6666_7777_8888;
    localparam logic [127:0] W26   = 128'hCAFE_0000_0000_0000_0000_0000_0000_F00D;
    localparam logic [127:0] W10   = 128'h0000_0000_0000_0000_0000_0000_1234_5678;

    typedef struct { logic [127:0] data; logic err; } rdExp_t;
    typedef struct { logic [15:0] addr; logic [127:0] data; logic last; } dumpExp_t;

    logic clk;
    logic rst;
    int   nCompared = 0;
    int   nMismatch = 0;
    int   initDoneCnt = 0;
    int   readValidCnt = 0;
    int   dumpValidCnt = 0;
    int   wrErrCnt = 0;

    rdExp_t   rdQ[$];
    dumpExp_t dumpQ[$];

    sram_responder_if #(.DATA_W(128)) bus ();

    sram_responder #(.ADDR_BITS(6), .DATA_W(128)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        nCompared++;
        if (act !== exp) begin
            nMismatch++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    // Scoreboard monitor
    always @(negedge clk) begin
        if (bus.initDone) initDoneCnt++;
        if (bus.sramAddrErr && !bus.sramReadValid) wrErrCnt++;
        if (bus.sramReadValid) begin
            readValidCnt++;
            if (rdQ.size() == 0) check("rdUnexpected", 128'd1, 128'd0);
            else begin
                rdExp_t e;
                e = rdQ.pop_front();
                check("rdData", bus.sramReadValue, e.data);
                check("rdAddrErr", 128'(bus.sramAddrErr), 128'(e.err));
            end
        end
        if (bus.dumpValid) begin
            dumpValidCnt++;
            if (dumpQ.size() == 0) check("dumpUnexpected", 128'd1, 128'd0);
            else begin
                dumpExp_t d;
                d = dumpQ.pop_front();
                check("dumpAddr", 128'(bus.dumpAddr), 128'(d.addr));
                check("dumpData", bus.dumpData, d.data);
                check("dumpLast", 128'(bus.dumpLast), 128'(d.last));
            end
        end
    end

    task automatic waitReady();
        for (int i = 0; i < 200; i++) begin
            if (bus.sramReady) return;
            @(posedge clk); #1;
        end
        check("readyTimeout", 128'd0, 128'd1);
    endtask

    task automatic doWrite(input logic [15:0] addr, input logic [127:0] data);
        bus.sramWrite = 1'b1; bus.sramAddr = addr; bus.sramWriteValue = data;
        @(posedge clk); #1;
        bus.sramWrite = 1'b0;
    endtask

    task automatic doRead(input logic [15:0] addr, input logic [127:0] expData, input logic expErr);
        rdQ.push_back('{data: expData, err: expErr});
        bus.sramRead = 1'b1; bus.sramAddr = addr;
        @(posedge clk); #1;
        bus.sramRead = 1'b0;
    endtask

    // Counts cycles with sramReady low after the command edge
    task automatic countBusy(output int busy, output logic doneAtRise);
        busy = 0; doneAtRise = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (bus.sramReady) begin
                doneAtRise = bus.initDone;
                return;
            end
            busy++;
        end
    endtask

    task automatic checkAllZero(input string tag);
        check({tag, "_ready"}, 128'(bus.sramReady), 128'd0);
        check({tag, "_rdValid"}, 128'(bus.sramReadValid), 128'd0);
        check({tag, "_rdValue"}, bus.sramReadValue, 128'd0);
        check({tag, "_addrErr"}, 128'(bus.sramAddrErr), 128'd0);
        check({tag, "_initDone"}, 128'(bus.initDone), 128'd0);
        check({tag, "_dumpValid"}, 128'(bus.dumpValid), 128'd0);
        check({tag, "_dumpLast"}, 128'(bus.dumpLast), 128'd0);
        check({tag, "_dumpAddr"}, 128'(bus.dumpAddr), 128'd0);
        check({tag, "_dumpData"}, bus.dumpData, 128'd0);
    endtask

    initial begin
        int busy;
        logic doneAtRise;
        int snap;
        bus.sramRead = 1'b0; bus.sramWrite = 1'b0; bus.sramAddr = '0;
        bus.sramWriteValue = '0; bus.sramInit = 1'b0; bus.sramInitNum = '0;
        bus.sramDump = 1'b0; bus.sramDumpNum = '0;
        rst = 1'b1;
        #3;
        checkAllZero("rstInit");
        repeat (2) @(posedge clk);
        #2 rst = 1'b0;
        #1 check("readyAfterRst", 128'(bus.sramReady), 128'd1);
        @(posedge clk); #1;

        // Write / read-after-write / back-to-back reads
        doWrite(16'd6, W6);
        doWrite(16'd5, BEEF);
        doRead(16'd5, BEEF, 1'b0);
        check("b2bValid0", 128'(bus.sramReadValid), 128'd1);
        doRead(16'd6, W6, 1'b0);
        check("b2bValid1", 128'(bus.sramReadValid), 128'd1);
        @(posedge clk); #1;
        check("rdHoldValid", 128'(bus.sramReadValid), 128'd0);
        check("rdHoldValue", bus.sramReadValue, W6);

        // Asynchronous mid-cycle reset
        #2 rst = 1'b1;
        #1 checkAllZero("rstMid");
        @(posedge clk); #2 rst = 1'b0;
        #1 check("readyAfterRst2", 128'(bus.sramReady), 128'd1);
        @(posedge clk); #1;

        // Init pattern 2
        snap = initDoneCnt;
        bus.sramInit = 1'b1; bus.sramInitNum = 3'd2;
        @(posedge clk); #1;
        bus.sramInit = 1'b0;
        check("initReadyDrop", 128'(bus.sramReady), 128'd0);
        countBusy(busy, doneAtRise);
        check("initBusyCycles", 128'(busy), 128'd64);
        check("initDoneAtRise", 128'(doneAtRise), 128'd1);
        @(posedge clk); #1;
        check("initDoneOnce", 128'(initDoneCnt - snap), 128'd1);
        doRead(16'd63, 128'h3F, 1'b0);
        doRead(16'd0, 128'h0, 1'b0);
        doRead(16'd7, 128'h7, 1'b0);

        // Init pattern 3, overwrite word 26, dump region 3
        waitReady();
        bus.sramInit = 1'b1; bus.sramInitNum = 3'd3;
        @(posedge clk); #1;
        bus.sramInit = 1'b0;
        waitReady();
        doWrite(16'd26, W26);
        for (int i = 0; i < 8; i++)
            dumpQ.push_back('{addr: 16'(24 + i), data: (i == 2) ? W26 : A5W, last: (i == 7)});
        snap = dumpValidCnt;
        bus.sramDump = 1'b1; bus.sramDumpNum = 3'd3;
        @(posedge clk); #1;
        bus.sramDump = 1'b0;
        check("dumpNoValidFirst", 128'(bus.dumpValid), 128'd0);
        countBusy(busy, doneAtRise);
        check("dumpBusyCycles", 128'(busy), 128'd9);
        check("dumpValidCount", 128'(dumpValidCnt - snap), 128'd8);
        check("dumpHoldAddr", 128'(bus.dumpAddr), 128'd31);
        check("dumpHoldData", bus.dumpData, A5W);

        // Write beats read in the same cycle
        @(posedge clk); #1;
        snap = readValidCnt;
        bus.sramWrite = 1'b1; bus.sramRead = 1'b1;
        bus.sramAddr = 16'd10; bus.sramWriteValue = W10;
        @(posedge clk); #1;
        bus.sramWrite = 1'b0; bus.sramRead = 1'b0;
        @(posedge clk); #1;
        check("prioNoRdPulse", 128'(readValidCnt - snap), 128'd0);
        doRead(16'd10, W10, 1'b0);

        // Out-of-range accesses
        doRead(16'd64, 128'h0, 1'b1);
        snap = wrErrCnt;
        doWrite(16'd100, ONESW);
        @(posedge clk); #1;
        check("wrOobErrPulse", 128'(wrErrCnt - snap), 128'd1);
        doRead(16'd36, A5W, 1'b0);

        // Reset in the middle of a pattern-1 init
        @(posedge clk); #1;
        snap = initDoneCnt;
        bus.sramInit = 1'b1; bus.sramInitNum = 3'd1;
        @(posedge clk); #1;
        bus.sramInit = 1'b0;
        repeat (9) @(posedge clk);
        #2 rst = 1'b1;
        #1 checkAllZero("rstInitMid");
        repeat (2) @(posedge clk);
        #2 rst = 1'b0;
        #1 check("readyAfterRst3", 128'(bus.sramReady), 128'd1);
        @(posedge clk); #1;
        doRead(16'd0, ONESW, 1'b0);
        doRead(16'd8, ONESW, 1'b0);
        doRead(16'd9, A5W, 1'b0);
        doRead(16'd26, W26, 1'b0);
        repeat (3) @(posedge clk);
        check("noInitDoneAfterRst", 128'(initDoneCnt - snap), 128'd0);

        for (int i = 0; i < 20 && (rdQ.size() != 0 || dumpQ.size() != 0); i++) @(posedge clk);
        check("rdQDrained", 128'(rdQ.size()), 128'd0);
        check("dumpQDrained", 128'(dumpQ.size()), 128'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatch);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
